// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the single-issue MIPS pipeline (EXE -> MEM -> WB).
// It issues loads and stores over a request/acknowledge data-memory port. It aligns,
// sign- or zero-extends and lane-replicates sub-word data. It stalls the upstream
// pipeline while an access is outstanding and loads bubbles into WB during the stall.
//
// Optional feature: define MEM_BYPASS_EN to enable the combinational MEM->EXE bypass.
// When it is undefined, the bypass outputs are tied to 0.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-low reset
//   *1_IN                      registered instruction/control/data from EXE
//   DMEM_Req/We/Addr/BE/WData  data-memory request (big-endian, word-aligned address)
//   DMEM_Ack/RData             data-memory completion and read word
//   STALL_OUT                  upstream hold while an access is outstanding
//   *1_OUT, Misaligned_OUT     registered results to WB
//   Bypass*1_MEMEXE            forwarding to EXE
//
// FSM states
//   state  | meaning
//   IDLE   | no access outstanding; a valid memory op requests in this cycle
//   WAIT   | request issued, waiting for DMEM_Ack; EXE holds its outputs
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instr1_IN,
    input  logic [31:0]       Instr1_PC_IN,
    input  logic [31:0]       ALU_result1_IN,
    input  logic [4:0]        WriteRegister1_IN,
    input  logic [31:0]       MemWriteData1_IN,
    input  logic              RegWrite1_IN,
    input  logic              MemRead1_IN,
    input  logic              MemWrite1_IN,
    input  logic [5:0]        ALU_Control1_IN,
    output logic              DMEM_Req,
    output logic              DMEM_We,
    output logic [ADDR_W-1:0] DMEM_Addr,
    output logic [3:0]        DMEM_BE,
    output logic [31:0]       DMEM_WData,
    input  logic              DMEM_Ack,
    input  logic [31:0]       DMEM_RData,
    output logic              STALL_OUT,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [31:0]       WriteData1_OUT,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic              Misaligned_OUT,
    output logic [4:0]        BypassReg1_MEMEXE,
    output logic [31:0]       BypassData1_MEMEXE,
    output logic              BypassValid1_MEMEXE
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state, state_nx;
    logic        memop, misaligned, mem_go, stall;
    logic        is_byte, is_half, is_word, is_signed;
    logic [1:0]  a;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic        mis_q;

    assign memop = MemRead1_IN | MemWrite1_IN;
    assign a     = ALU_result1_IN[1:0];

    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (ALU_Control1_IN)
            OP_LB:         begin is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU, OP_SB: is_byte = 1'b1;
            OP_LH:         begin is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU, OP_SH: is_half = 1'b1;
            OP_LW, OP_SW:  is_word = 1'b1;
            default:       is_word = 1'b1;  // unknown memory opcode: full-word access
        endcase
    end

    assign misaligned = memop & ((is_half & a[0]) | (is_word & (a != 2'b00)));
    assign mem_go     = memop & ~misaligned;
    assign stall      = mem_go & ~DMEM_Ack;

    // Big-endian lane selection: byte offset 0 lives in bits 31:24.
    always_comb begin
        case (a)
            2'd0:    ld_byte = DMEM_RData[31:24];
            2'd1:    ld_byte = DMEM_RData[23:16];
            2'd2:    ld_byte = DMEM_RData[15:8];
            default: ld_byte = DMEM_RData[7:0];
        endcase
        ld_half = a[1] ? DMEM_RData[15:0] : DMEM_RData[31:16];
        if (is_byte)
            load_data = is_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
        else if (is_half)
            load_data = is_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
        else
            load_data = DMEM_RData;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (mem_go && !DMEM_Ack) state_nx = S_WAIT;
            S_WAIT:  if (!mem_go || DMEM_Ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic. EXE holds its outputs while stalled, so the request fields stay
    // stable in WAIT without being re-registered here.
    always_comb begin
        DMEM_Req   = 1'b0;
        DMEM_We    = 1'b0;
        STALL_OUT  = 1'b0;
        DMEM_Addr  = {ALU_result1_IN[ADDR_W-1:2], 2'b00};
        DMEM_BE    = 4'b1111;
        DMEM_WData = MemWriteData1_IN;
        if (is_byte) begin
            DMEM_BE    = 4'b1000 >> a;
            DMEM_WData = {4{MemWriteData1_IN[7:0]}};
        end else if (is_half) begin
            DMEM_BE    = a[1] ? 4'b0011 : 4'b1100;
            DMEM_WData = {2{MemWriteData1_IN[15:0]}};
        end
        if (RESET && (state == S_IDLE || state == S_WAIT)) begin
            DMEM_Req  = mem_go;
            DMEM_We   = mem_go & MemWrite1_IN;
            STALL_OUT = stall;
        end
    end

    // WB pipeline registers; stalled or misaligned cycles load a bubble.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            WriteData1_OUT     <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            mis_q              <= 1'b0;
        end else if (stall || misaligned) begin
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            WriteData1_OUT     <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            mis_q              <= misaligned;
        end else begin
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            WriteData1_OUT     <= MemRead1_IN ? load_data : ALU_result1_IN;
            WriteRegister1_OUT <= WriteRegister1_IN;
            RegWrite1_OUT      <= RegWrite1_IN & ~MemWrite1_IN;
            mis_q              <= 1'b0;
        end
    end

    assign Misaligned_OUT = mis_q & RESET;

`ifdef MEM_BYPASS_EN
    assign BypassValid1_MEMEXE = RESET & RegWrite1_IN & (WriteRegister1_IN != 5'd0)
                               & ~stall & ~misaligned;
    assign BypassData1_MEMEXE  = MemRead1_IN ? load_data : ALU_result1_IN;
    assign BypassReg1_MEMEXE   = WriteRegister1_IN;
`else
    assign BypassValid1_MEMEXE = 1'b0;
    assign BypassData1_MEMEXE  = '0;
    assign BypassReg1_MEMEXE   = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic        DMEM_Req, DMEM_We, DMEM_Ack;
    logic [31:0] DMEM_Addr, DMEM_WData, DMEM_RData;
    logic [3:0]  DMEM_BE;
    logic        STALL_OUT;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT, Misaligned_OUT;
    logic [4:0]  BypassReg1_MEMEXE;
    logic [31:0] BypassData1_MEMEXE;
    logic        BypassValid1_MEMEXE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_stage #(.ADDR_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
        .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
        .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
        .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .ALU_Control1_IN(ALU_Control1_IN),
        .DMEM_Req(DMEM_Req), .DMEM_We(DMEM_We), .DMEM_Addr(DMEM_Addr),
        .DMEM_BE(DMEM_BE), .DMEM_WData(DMEM_WData),
        .DMEM_Ack(DMEM_Ack), .DMEM_RData(DMEM_RData),
        .STALL_OUT(STALL_OUT),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
        .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
        .RegWrite1_OUT(RegWrite1_OUT), .Misaligned_OUT(Misaligned_OUT),
        .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
        .BypassValid1_MEMEXE(BypassValid1_MEMEXE)
    );

    task automatic clear_inputs();
        Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
        WriteRegister1_IN = '0; RegWrite1_IN = 1'b0; MemRead1_IN = 1'b0;
        MemWrite1_IN = 1'b0; ALU_Control1_IN = '0; DMEM_Ack = 1'b0; DMEM_RData = '0;
    endtask

    // Runs one instruction through the stage from posedge+1 to posedge+1 of its
    // retire cycle, checking the request side at each negedge and WB after each edge.
    task automatic do_op(input logic [5:0] opc, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input logic [4:0] wreg,
                         input logic rw, input int delay,
                         input logic [31:0] instr, input logic [31:0] pc);
        logic mem, mis, byte_op, half, word, sgn, exp_stall, exp_bv;
        logic [3:0]  be;
        logic [31:0] wd, ld, b, h, exp_wb;
        int off, n;
        mem = rd | wr;
        off = int'(addr[1:0]);
        byte_op = (opc == 6'h20) || (opc == 6'h24) || (opc == 6'h28);
        half    = (opc == 6'h21) || (opc == 6'h25) || (opc == 6'h29);
        word    = (opc == 6'h23) || (opc == 6'h2B);
        sgn     = (opc == 6'h20) || (opc == 6'h21);
        mis = mem && ((half && (off % 2 == 1)) || (word && off != 0));
        be  = byte_op ? (4'b1000 >> off) : half ? ((off < 2) ? 4'b1100 : 4'b0011) : 4'b1111;
        wd  = byte_op ? (wdat & 32'hFF) * 32'h0101_0101
            : half ? (wdat & 32'hFFFF) * 32'h0001_0001 : wdat;
        b   = (rdat >> (8 * (3 - off))) & 32'hFF;
        h   = (rdat >> (16 * (1 - off / 2))) & 32'hFFFF;
        ld  = byte_op ? ((sgn && b >= 32'd128) ? b + 32'hFFFF_FF00 : b)
            : half ? ((sgn && h >= 32'd32768) ? h + 32'hFFFF_0000 : h) : rdat;
        exp_wb = rd ? ld : addr;
        n = (mem && !mis) ? delay : 0;

        Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = addr;
        MemWriteData1_IN = wdat; WriteRegister1_IN = wreg; RegWrite1_IN = rw;
        MemRead1_IN = rd; MemWrite1_IN = wr; ALU_Control1_IN = opc;
        DMEM_RData = rdat;
        for (int c = 0; c <= n; c++) begin
            DMEM_Ack = (c == n) && mem;
            @(negedge CLK);
            exp_stall = mem && !mis && (c < n);
`ifdef MEM_BYPASS_EN
            exp_bv = rw && (wreg != 5'd0) && !exp_stall && !mis;
`else
            exp_bv = 1'b0;
`endif
            checks++;
            if (DMEM_Req !== (mem && !mis)) begin
                errors++; $display("FAIL req op=%h c=%0d got %b want %b", opc, c, DMEM_Req, mem && !mis);
            end
            checks++;
            if (STALL_OUT !== exp_stall) begin
                errors++; $display("FAIL stall op=%h c=%0d got %b want %b", opc, c, STALL_OUT, exp_stall);
            end
            if (mem && !mis) begin
                checks++;
                if ({DMEM_Addr, DMEM_BE, DMEM_We} !== {addr & 32'hFFFF_FFFC, be, wr}) begin
                    errors++; $display("FAIL dmem_ctl op=%h got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                        opc, DMEM_Addr, DMEM_BE, DMEM_We, addr & 32'hFFFF_FFFC, be, wr);
                end
                if (wr) begin
                    checks++;
                    if (DMEM_WData !== wd) begin
                        errors++; $display("FAIL wdata op=%h got %h want %h", opc, DMEM_WData, wd);
                    end
                end
            end
            checks++;
            if (BypassValid1_MEMEXE !== exp_bv) begin
                errors++; $display("FAIL byp_valid op=%h got %b want %b", opc, BypassValid1_MEMEXE, exp_bv);
            end
            if (exp_bv) begin
                checks++;
                if ({BypassReg1_MEMEXE, BypassData1_MEMEXE} !== {wreg, exp_wb}) begin
                    errors++; $display("FAIL byp_data got r%0d %h want r%0d %h",
                        BypassReg1_MEMEXE, BypassData1_MEMEXE, wreg, exp_wb);
                end
            end
            @(posedge CLK); #1;
            if (exp_stall) begin
                checks++;
                if ({RegWrite1_OUT, Instr1_OUT, Instr1_PC_OUT, WriteRegister1_OUT} !== '0) begin
                    errors++; $display("FAIL bubble op=%h c=%0d got rw=%b instr=%h pc=%h wr=%0d want zeros",
                        opc, c, RegWrite1_OUT, Instr1_OUT, Instr1_PC_OUT, WriteRegister1_OUT);
                end
            end else begin
                checks++;
                if ({Misaligned_OUT, RegWrite1_OUT} !== {mis, rw && !wr && !mis}) begin
                    errors++; $display("FAIL retire_flags op=%h got mis=%b rw=%b want mis=%b rw=%b",
                        opc, Misaligned_OUT, RegWrite1_OUT, mis, rw && !wr && !mis);
                end
                if (!mis) begin
                    checks++;
                    if ({Instr1_OUT, Instr1_PC_OUT, WriteRegister1_OUT} !== {instr, pc, wreg}) begin
                        errors++; $display("FAIL retire_tags got %h %h %0d want %h %h %0d",
                            Instr1_OUT, Instr1_PC_OUT, WriteRegister1_OUT, instr, pc, wreg);
                    end
                    if (!wr) begin
                        checks++;
                        if (WriteData1_OUT !== exp_wb) begin
                            errors++; $display("FAIL wb_data op=%h addr=%h got %h want %h",
                                opc, addr, WriteData1_OUT, exp_wb);
                        end
                    end
                end
            end
        end
        DMEM_Ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({DMEM_Req, STALL_OUT, Misaligned_OUT, BypassValid1_MEMEXE, RegWrite1_OUT,
             Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, WriteRegister1_OUT} !== '0) begin
            errors++;
            $display("FAIL %s got req=%b stall=%b mis=%b bv=%b rw=%b instr=%h pc=%h wd=%h wr=%0d want all 0",
                tag, DMEM_Req, STALL_OUT, Misaligned_OUT, BypassValid1_MEMEXE, RegWrite1_OUT,
                Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, WriteRegister1_OUT);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1'b0;
        MemRead1_IN = 1'b1; ALU_Control1_IN = 6'h23;
        repeat (3) @(posedge CLK);
        #1 check_all_zero("reset_state");
        clear_inputs();
        @(negedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_alu();
        do_op(6'h00, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 32'hAAAA_0001, 32'h0040_0000);
        do_op(6'h00, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b1, 0, 32'hAAAA_0002, 32'h0040_0004);
    endtask

    task automatic test_lb();
        do_op(6'h20, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 32'h11F2_3344, 5'd7, 1'b1, 0, 32'h8000_0101, 32'h0040_0008);
        do_op(6'h24, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 32'h11F2_3344, 5'd7, 1'b1, 0, 32'h9000_0101, 32'h0040_000C);
    endtask

    task automatic test_lw_wait();
        do_op(6'h23, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 3, 32'h8C00_0400, 32'h0040_0010);
    endtask

    task automatic test_sh();
        do_op(6'h29, 1'b0, 1'b1, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd3, 1'b0, 1, 32'hA400_0202, 32'h0040_0014);
    endtask

    task automatic test_misaligned();
        do_op(6'h23, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h1234_5678, 5'd4, 1'b1, 2, 32'h8C00_0103, 32'h0040_0018);
        do_op(6'h29, 1'b0, 1'b1, 32'h0000_0105, 32'h5555, 32'h0, 5'd0, 1'b0, 2, 32'hA400_0105, 32'h0040_001C);
    endtask

    task automatic test_back_to_back();
        do_op(6'h2B, 1'b0, 1'b1, 32'h0000_0800, 32'h0123_4567, 32'h0, 5'd0, 1'b0, 0, 32'h1, 32'h100);
        do_op(6'h25, 1'b1, 1'b0, 32'h0000_0802, 32'h0, 32'h8001_FEDC, 5'd8, 1'b1, 0, 32'h2, 32'h104);
        do_op(6'h21, 1'b1, 1'b0, 32'h0000_0802, 32'h0, 32'h8001_FEDC, 5'd8, 1'b1, 0, 32'h3, 32'h108);
        do_op(6'h28, 1'b0, 1'b1, 32'h0000_0803, 32'h0000_00A5, 32'h0, 5'd0, 1'b0, 0, 32'h4, 32'h10C);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] opc;
        logic [31:0] addr;
        logic rd, wr;
        int k;
        ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h23; ops[3] = 6'h24;
        ops[4] = 6'h25; ops[5] = 6'h28; ops[6] = 6'h29; ops[7] = 6'h2B;
        for (int i = 0; i < 200; i++) begin
            k = int'($urandom_range(0, 8));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            if (k == 8) begin
                opc = 6'($urandom_range(0, 31)); rd = 1'b0; wr = 1'b0;
            end else begin
                opc = ops[k]; rd = (k < 5); wr = (k >= 5);
            end
            do_op(opc, rd, wr, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_bv;
        clear_inputs();
        MemRead1_IN = 1'b1; ALU_Control1_IN = 6'h23; ALU_result1_IN = 32'h0000_0C00;
        RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd6; Instr1_IN = 32'h77; Instr1_PC_IN = 32'h88;
        @(negedge CLK);
        checks++;
        if ({DMEM_Req, STALL_OUT} !== 2'b11) begin
            errors++; $display("FAIL mid_req_pre got req=%b stall=%b want 1 1", DMEM_Req, STALL_OUT);
        end
        @(posedge CLK); @(posedge CLK); #2;
        RESET = 1'b0;
        #1 check_all_zero("reset_mid_wait");
        clear_inputs();
        DMEM_Ack = 1'b1;
        @(negedge CLK); #1 RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if ({DMEM_Req, STALL_OUT} !== 2'b00) begin
            errors++; $display("FAIL late_ack got req=%b stall=%b want 0 0", DMEM_Req, STALL_OUT);
        end
        @(posedge CLK); #1;
        DMEM_Ack = 1'b0;
        do_op(6'h00, 1'b0, 1'b0, 32'h0000_5678, 32'h0, 32'h0, 5'd12, 1'b1, 0, 32'h99, 32'hAA);
        ALU_result1_IN = 32'h0000_0042; WriteRegister1_IN = 5'd13; RegWrite1_IN = 1'b1;
        MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
        @(negedge CLK);
`ifdef MEM_BYPASS_EN
        exp_bv = 1'b1;
`else
        exp_bv = 1'b0;
`endif
        checks++;
        if (BypassValid1_MEMEXE !== exp_bv) begin
            errors++; $display("FAIL post_reset_bypass got %b want %b", BypassValid1_MEMEXE, exp_bv);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_lw_wait();
        test_sh();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the single-issue MIPS pipeline. It sits between EXE and WB. It consumes EXE's registered outputs and performs loads and stores over a request/acknowledge data-memory port. It also aligns, sign-extends and merges sub-word data, and drives the MEM→EXE bypass consumed by EXE's operand forwarding. While a memory access is outstanding it stalls the upstream pipeline and inserts bubbles into WB.

## Interface
Parameters:
- `ADDR_W`, default 32: data-memory address width.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `Instr1_IN`, `Instr1_PC_IN`  in  32 each  debug instruction and PC from EXE.
- `ALU_result1_IN`  in  32  ALU result, or effective address for memory ops.
- `WriteRegister1_IN`  in  5  destination register.
- `MemWriteData1_IN`  in  32  store data, already forwarded by EXE.
- `RegWrite1_IN`, `MemRead1_IN`, `MemWrite1_IN`  in  1 each  control from EXE.
- `ALU_Control1_IN`  in  6  for memory ops, carries the MIPS opcode: LB 6'h20, LH 6'h21, LW 6'h23, LBU 6'h24, LHU 6'h25, SB 6'h28, SH 6'h29, SW 6'h2B.
- `DMEM_Req`  out  1  access request.
- `DMEM_We`  out  1  1 = store.
- `DMEM_Addr`  out  ADDR_W  word-aligned address.
- `DMEM_BE`  out  4  byte enables; bit 3 = bits 31:24.
- `DMEM_WData`  out  32  lane-replicated store data.
- `DMEM_Ack`  in  1  access complete; read data valid this cycle.
- `DMEM_RData`  in  32  read word.
- `STALL_OUT`  out  1  upstream stages hold when 1.
- `Instr1_OUT`, `Instr1_PC_OUT`  out  32 each  debug outputs to WB.
- `WriteData1_OUT`  out  32  register write value.
- `WriteRegister1_OUT`  out  5  destination register to WB.
- `RegWrite1_OUT`  out  1  register write enable to WB.
- `Misaligned_OUT`  out  1  one-cycle flag for a misaligned access.
- `BypassReg1_MEMEXE`  out  5  bypass register number to EXE.
- `BypassData1_MEMEXE`  out  32  bypass data to EXE.
- `BypassValid1_MEMEXE`  out  1  bypass valid to EXE.

## Operation
- Memory op is `MemRead1_IN | MemWrite1_IN`. Any other instruction is an ALU op and passes through in one cycle with `WriteData1 = ALU_result1_IN`.
- Memory is big-endian. Byte at offset 0 is lanes 31:24.
- `DMEM_Addr = {ALU_result1_IN[ADDR_W-1:2], 2'b00}`.
- Byte enables:
  - LB/SB: one-hot on `addr[1:0]`.
  - LH/SH: `addr[1]=0` → 4'b1100, else 4'b0011.
  - LW/SW: 4'b1111.
- Store data: SB replicates byte ×4, SH replicates half ×2, SW is passed unchanged.
- Load data: selects the lane, then sign-extends (LB, LH) or zero-extends (LBU, LHU).
- Misaligned access: LH/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`.
  - `Misaligned_OUT` pulses, no request is issued, and the instruction retires as a bubble (`RegWrite1_OUT=0`).
- FSM states are IDLE and WAIT.
  - IDLE, memory op: `DMEM_Req=1` combinationally. If `DMEM_Ack` arrives the same cycle, retire at this edge and stay in IDLE. Otherwise go to WAIT.
  - WAIT: hold `DMEM_Req`, address, enables and data stable. On `DMEM_Ack`, retire and return to IDLE.
- `STALL_OUT = memop & ~DMEM_Ack & ~misaligned`, in IDLE or WAIT. EXE holds its outputs while it is 1.
- Every stalled cycle loads a bubble into the WB registers: `RegWrite1_OUT=0`, `Instr1_OUT=0`, `Instr1_PC_OUT=0`, `WriteRegister1_OUT=0`.
- Stores always retire with `RegWrite1_OUT=0`.
- A write to register 0 is passed to WB unchanged but is never bypassed.

## Timing
- Reset value of every registered output is 0, and the FSM resets to IDLE.
- While `RESET=0`, `DMEM_Req`, `STALL_OUT`, `Misaligned_OUT` and `BypassValid1_MEMEXE` are forced to 0 combinationally.
- Reset asserted mid-access abandons the request immediately. A late `DMEM_Ack` after reset is ignored in IDLE when no memory op is present.
- Latency:
  - ALU op: 1 cycle to WB.
  - Load/store: 1 + N cycles, where N is the number of cycles without `DMEM_Ack`.
- Back-to-back memory ops: the next request may assert in the cycle after an Ack.
- `DMEM_Ack` with `DMEM_Req=0` is ignored.

## Configuration
- `MEM_BYPASS_EN` defined:
  - Bypass outputs are combinational from the current inputs.
  - Valid = `RegWrite1_IN & (WriteRegister1_IN≠0) & ~STALL_OUT & ~misaligned`.
  - Data = load result (on Ack) or `ALU_result1_IN`.
  - Reg = `WriteRegister1_IN`.
- Not defined: bypass outputs are tied to 0, and EXE falls back to its own ALU-result forwarding only.

## Test plan
- ALU op `ALU_result1_IN=32'h0000_1234`, `RegWrite1_IN=1`, `WriteRegister1_IN=5` → next cycle `WriteData1_OUT=32'h1234`, `RegWrite1_OUT=1`; bypass valid same cycle with reg 5.
- LB at address 0x101, `DMEM_RData=32'h11_F2_33_44`, Ack in 0 cycles → `DMEM_BE=4'b0100`, `WriteData1_OUT=32'hFFFF_FFF2`; LBU of the same → 32'h0000_00F2.
- LW with Ack after 3 cycles → `STALL_OUT` high for 3 cycles, 3 bubbles in WB, then data retires; `DMEM_Addr` stable throughout.
- SH at 0x202, data 32'h0000_ABCD → `DMEM_BE=4'b0011`, `DMEM_WData=32'hABCD_ABCD`, `DMEM_We=1`, `RegWrite1_OUT=0`.
- LW at 0x103 → `Misaligned_OUT` pulse, `DMEM_Req` stays 0, no stall, bubble retires.
- RESET low during WAIT → `DMEM_Req` 0 immediately, all outputs 0. After release, an ALU op passes normally; with `MEM_BYPASS_EN` undefined, `BypassValid1_MEMEXE` stays 0.
